branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and misprediction resolver placed directly upstream of the fetch stage. Every cycle it looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It drives `prediction`/`control_pc` so fetch can redirect on a predicted-taken branch. When a resolved branch arrives from the EX/MEM register, it trains the table and produces `flush`/`pc_branch` for fetch on a misprediction.

## Interface
Parameters:
- `IDX_W`, 4: BTB index width; the BTB has 2**`IDX_W` entries. Tag width is 30-`IDX_W` bits (PC[31:`IDX_W`+2]).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_pc`  in  32  current fetch PC (fetch stage `cpc`).
- `prediction`  out  1  1 = predicted taken; fetch loads `control_pc`.
- `control_pc`  out  32  predicted next PC.
- `ex_valid`  in  1  a valid instruction is in EX/MEM this cycle.
- `ex_is_branch`  in  1  that instruction is a control transfer (conditional or unconditional).
- `ex_pc`  in  32  its PC.
- `ex_taken`  in  1  resolved direction.
- `ex_target`  in  32  resolved taken target.
- `ex_pred`  in  1  `prediction` value carried down the pipeline with this instruction.
- `ex_pred_target`  in  32  `control_pc` value carried with it.
- `flush`  out  1  misprediction; fetch must load `pc_branch`.
- `pc_branch`  out  32  correct next PC after the resolved instruction.
- `br_cnt`  out  32  resolved control transfers since reset.
- `miss_cnt`  out  32  mispredictions since reset.

## Operation
- Entry fields: `valid`, `tag`, `target[31:0]`, `ctr[1:0]`.
- Reset values:
  - all `valid`=0 and all `ctr`=2'b01.
  - `br_cnt`=0 and `miss_cnt`=0.
  - Outputs with `ex_valid`=0: `prediction`=0, `control_pc`=`if_pc`+4, `flush`=0. `pc_branch` is don't-care while `flush`=0.
- Lookup (combinational from registered state):
  - index `if_pc[IDX_W+1:2]`; hit = `valid` & tag match.
  - `prediction` = hit & `ctr[1]`.
  - `control_pc` = `prediction` ? `target` : `if_pc`+4.
  - `if_pc[1:0]` is ignored.
- Resolution (combinational, when `ex_valid`):
  - Branch case (`ex_is_branch`=1): `flush` = (`ex_pred`≠`ex_taken`) | (`ex_pred` & `ex_taken` & `ex_pred_target`≠`ex_target`).
  - Non-branch case (`ex_is_branch`=0, alias hit): `flush` = `ex_pred`.
  - `pc_branch` = (`ex_is_branch` & `ex_taken`) ? `ex_target` : `ex_pc`+4.
  - All +4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 = 0.
- Training at the rising edge when `ex_valid` & `ex_is_branch`. The entry is indexed and tagged by `ex_pc`.
  - Hit, taken: `ctr` = min(`ctr`+1, 3); `target` ← `ex_target`.
  - Hit, not taken: `ctr` = max(`ctr`-1, 0); `target` unchanged.
  - Miss, taken: allocate, overwriting any prior occupant. Set `valid`=1, tag, `target`=`ex_target`, `ctr`=2'b10.
  - Miss, not taken: no change.
- Alias cleanup: when `ex_valid` & !`ex_is_branch` & `ex_pred`, clear `valid` of the entry indexed by `ex_pc` if its tag matches.
- Statistics at the rising edge:
  - `br_cnt` += 1 when `ex_valid` & `ex_is_branch`.
  - `miss_cnt` += 1 when `flush`.
  - Both wrap modulo 2^32.
- Fetch stalls (NOP) need no input here: lookup is stateless, so a held `if_pc` gives a stable prediction.

## Timing
- Lookup latency: 0 cycles. `prediction`/`control_pc` are valid in the same cycle as `if_pc` and are sampled by fetch at the next edge.
- Resolution latency: 0 cycles. `flush`/`pc_branch` are valid in the same cycle as `ex_valid`, which comes from a registered EX/MEM source.
- Training is visible to lookup one cycle after the edge that writes it.
- Simultaneous lookup and training of the same index: the lookup returns pre-update contents. There is no write-to-read bypass.
- Fetch gives `flush` priority over `prediction` in the same cycle; the predictor need not suppress `prediction`.
- Reset asserted mid-operation: all state and counters clear immediately (asynchronous). Outputs take their reset values while `rst`=0.
- Reset release: the first training edge is the first rising edge with `rst`=1.

## Test plan
- Reset, then `if_pc`=0x100 → `prediction`=0, `control_pc`=0x104, `br_cnt`=`miss_cnt`=0.
- Cold miss: resolve `ex_pc`=0x100, taken, `ex_target`=0x200, `ex_pred`=0 → `flush`=1, `pc_branch`=0x200. Next cycle, `if_pc`=0x100 gives `prediction`=1, `control_pc`=0x200; `br_cnt`=1, `miss_cnt`=1.
- Counter walk on 0x100 starting at `ctr`=2'b10:
  - Taken, taken → saturates at 3.
  - Three not-taken → `ctr`=0, `prediction`=0.
  - Then one taken → `ctr`=1, still `prediction`=0.
- Target change: `ex_pred`=1, `ex_pred_target`=0x200, taken to 0x300 → `flush`=1, `pc_branch`=0x300; the next lookup gives 0x300.
- Alias: entry for 0x100 is resident. Resolve 0x140 (same index when `IDX_W`=4, different tag) taken to 0x500 → lookup 0x100 misses (`control_pc`=0x104). A non-branch resolution at 0x140 with `ex_pred`=1 → `flush`=1, `pc_branch`=0x144, and the entry is invalidated.
- Same-cycle lookup/train of 0x100 returns old data; `rst` pulsed low mid-stream clears all entries and both counters immediately.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/EX-MEM side signal bundle for the branch predictor.
// master: pipeline side (drives PCs and resolution info).
// slave: predictor side (drives prediction, flush and statistics).
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        prediction;
  logic [31:0] control_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] pc_branch;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred, ex_pred_target,
    input  prediction, control_pc, flush, pc_branch, br_cnt, miss_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred, ex_pred_target,
    output prediction, control_pc, flush, pc_branch, br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. Zero-latency lookup
// of the fetch PC, zero-latency misprediction detection for the resolved
// EX/MEM instruction, training and statistics on the rising edge.
module branch_predictor #(
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bus
);
  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = 30 - IDX_W;

  logic             e_valid  [ENTRIES];
  logic [TAG_W-1:0] e_tag    [ENTRIES];
  logic [31:0]      e_target [ENTRIES];
  logic [1:0]       e_ctr    [ENTRIES];

  logic [31:0] br_cnt_q;
  logic [31:0] miss_cnt_q;

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic             pred;

  logic [IDX_W-1:0] t_idx;
  logic [TAG_W-1:0] t_tag;
  logic             t_hit;
  logic             flush;

  assign l_idx = bus.if_pc[IDX_W+1:2];
  assign l_tag = bus.if_pc[31:IDX_W+2];
  assign l_hit = e_valid[l_idx] && (e_tag[l_idx] == l_tag);
  assign pred  = l_hit && e_ctr[l_idx][1];

  assign bus.prediction = pred;
  assign bus.control_pc = pred ? e_target[l_idx] : bus.if_pc + 32'd4;

  assign t_idx = bus.ex_pc[IDX_W+1:2];
  assign t_tag = bus.ex_pc[31:IDX_W+2];
  assign t_hit = e_valid[t_idx] && (e_tag[t_idx] == t_tag);

  // Misprediction detection for the instruction in EX/MEM; held low in reset.
  always_comb begin
    flush = 1'b0;
    if (rst && bus.ex_valid) begin
      if (bus.ex_is_branch)
        flush = (bus.ex_pred != bus.ex_taken) ||
                (bus.ex_pred && bus.ex_taken && (bus.ex_pred_target != bus.ex_target));
      else
        flush = bus.ex_pred;
    end
  end

  assign bus.flush     = flush;
  assign bus.pc_branch = (bus.ex_is_branch && bus.ex_taken) ? bus.ex_target
                                                             : bus.ex_pc + 32'd4;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

  // BTB training, alias invalidation and statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        e_valid[i]  <= 1'b0;
        e_tag[i]    <= '0;
        e_target[i] <= '0;
        e_ctr[i]    <= 2'b01;
      end
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (bus.ex_valid && bus.ex_is_branch) begin
        br_cnt_q <= br_cnt_q + 32'd1;
        if (t_hit) begin
          if (bus.ex_taken) begin
            if (e_ctr[t_idx] != 2'b11) e_ctr[t_idx] <= e_ctr[t_idx] + 2'd1;
            e_target[t_idx] <= bus.ex_target;
          end else if (e_ctr[t_idx] != 2'b00) begin
            e_ctr[t_idx] <= e_ctr[t_idx] - 2'd1;
          end
        end else if (bus.ex_taken) begin
          e_valid[t_idx]  <= 1'b1;
          e_tag[t_idx]    <= t_tag;
          e_target[t_idx] <= bus.ex_target;
          e_ctr[t_idx]    <= 2'b10;
        end
      end else if (bus.ex_valid && bus.ex_pred && t_hit) begin
        e_valid[t_idx] <= 1'b0;
      end
      if (flush) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a stimulus process drives one
// cycle at a time and queues the expected outputs from a table model;
// a monitor pops and compares each cycle.
module tb_branch_predictor;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned ENT   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  branch_predictor_if bus ();

  branch_predictor #(.IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pred;
    logic [31:0] cpc;
    logic        flush;
    logic [31:0] pcb;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: per-slot table with integer counters.
  bit          m_valid [ENT];
  logic [31:0] m_tagv  [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  logic [31:0] m_br;
  logic [31:0] m_miss;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc >> 2) % ENT;
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0;
      m_tagv[i]  = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_br   = '0;
    m_miss = '0;
  endtask

  task automatic drive(bit r, logic [31:0] ifpc, bit v, bit br, logic [31:0] pc,
                       bit tk, logic [31:0] tgt, bit pr, logic [31:0] prt);
    exp_t        e;
    int unsigned li, ti;
    bit          hit, th, f;
    @(negedge clk);
    rst                = r;
    bus.if_pc          = ifpc;
    bus.ex_valid       = v;
    bus.ex_is_branch   = br;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred        = pr;
    bus.ex_pred_target = prt;
    if (!r) model_reset();
    li     = idx_of(ifpc);
    hit    = m_valid[li] && (m_tagv[li] == tag_of(ifpc));
    e.pred = hit && (m_ctr[li] >= 2);
    e.cpc  = e.pred ? m_tgt[li] : ifpc + 32'd4;
    f = 0;
    if (r && v) f = br ? ((pr != tk) || (pr && tk && prt != tgt)) : pr;
    e.flush = f;
    e.pcb   = (br && tk) ? tgt : pc + 32'd4;
    e.br    = m_br;
    e.miss  = m_miss;
    q.push_back(e);
    if (r && v) begin
      ti = idx_of(pc);
      th = m_valid[ti] && (m_tagv[ti] == tag_of(pc));
      if (br) begin
        m_br = m_br + 32'd1;
        if (th) begin
          if (tk) begin
            m_ctr[ti] = (m_ctr[ti] + 1 > 3) ? 3 : m_ctr[ti] + 1;
            m_tgt[ti] = tgt;
          end else begin
            m_ctr[ti] = (m_ctr[ti] - 1 < 0) ? 0 : m_ctr[ti] - 1;
          end
        end else if (tk) begin
          m_valid[ti] = 1;
          m_tagv[ti]  = tag_of(pc);
          m_tgt[ti]   = tgt;
          m_ctr[ti]   = 2;
        end
      end else if (pr && th) begin
        m_valid[ti] = 0;
      end
      if (f) m_miss = m_miss + 32'd1;
    end
  endtask

  task automatic look(logic [31:0] ifpc);
    drive(1, ifpc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic resolve(logic [31:0] ifpc, bit br, logic [31:0] pc, bit tk,
                         logic [31:0] tgt, bit pr, logic [31:0] prt);
    drive(1, ifpc, 1, br, pc, tk, tgt, pr, prt);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("prediction", {31'b0, bus.prediction}, {31'b0, e.pred});
        chk("control_pc", bus.control_pc, e.cpc);
        chk("flush", {31'b0, bus.flush}, {31'b0, e.flush});
        if (e.flush) chk("pc_branch", bus.pc_branch, e.pcb);
        chk("br_cnt", bus.br_cnt, e.br);
        chk("miss_cnt", bus.miss_cnt, e.miss);
      end
    end
  end

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 7))
      0: return 32'h100;
      1: return 32'h140;
      2: return 32'h180;
      3: return 32'h104;
      4: return 32'h1C0;
      5: return 32'hFFFF_FFFC;
      6: return 32'h200;
      default: return $urandom() & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    logic [31:0] p, t;
    model_reset();
    bus.if_pc = 32'h100; bus.ex_valid = 0; bus.ex_is_branch = 0;
    bus.ex_pc = 0; bus.ex_taken = 0; bus.ex_target = 0;
    bus.ex_pred = 0; bus.ex_pred_target = 0;

    // Reset, then idle lookup
    drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    look(32'h100);
    // Cold miss then hit
    resolve(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    look(32'h100);
    // Counter walk: saturate, decay to 0, one taken leaves prediction off
    resolve(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    resolve(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    look(32'h100);
    for (int i = 0; i < 3; i++) resolve(32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200);
    look(32'h100);
    resolve(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    look(32'h100);
    // Target change
    resolve(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    resolve(32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h200);
    look(32'h100);
    // Alias at same index, then non-branch alias cleanup
    resolve(32'h100, 1, 32'h140, 1, 32'h500, 0, 32'h0);
    look(32'h100);
    look(32'h140);
    resolve(32'h140, 0, 32'h140, 0, 32'h0, 1, 32'h500);
    look(32'h140);
    // Same-cycle lookup and training returns old contents
    resolve(32'h100, 1, 32'h100, 1, 32'h600, 0, 32'h0);
    resolve(32'h100, 1, 32'h100, 1, 32'h700, 1, 32'h600);
    look(32'h100);
    // Wraparound of +4
    resolve(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0);
    look(32'hFFFF_FFFC);
    // Mid-stream reset clears entries and counters
    drive(0, 32'h100, 1, 1, 32'h100, 1, 32'h900, 0, 32'h0);
    look(32'h100);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      p = pick_pc();
      t = ($urandom_range(0, 1) != 0) ? pick_pc() : 32'h800;
      drive(($urandom_range(0, 99) != 0), pick_pc(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, p, $urandom_range(0, 1) != 0, t,
            $urandom_range(0, 1) != 0,
            ($urandom_range(0, 1) != 0) ? t : pick_pc());
    end

    look(32'h0);
    repeat (3) @(negedge clk);
    #4;
    if (q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
